fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage. Generates the PC, issues word requests to the instruction memory, and buffers in-order responses in a small queue.
- Presents {instruction, program_counter, valid} to the IF/ID pipeline register and honours its stall.
- Accepts a redirect (branch/jump/trap target) that flushes all in-flight work.
- Is the producer side of the fetch/decode interface.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 2, response queue entries; also the credit limit on outstanding requests (power of 2, >=2).

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- req_valid  output  1  imem request valid
- req_addr  output  32  imem word address (bits [1:0] always 0)
- req_ready  input  1  imem accepts request this cycle
- resp_valid  input  1  imem response strobe, in order, no back-pressure
- resp_data  input  32  instruction word
- stall  input  1  downstream not accepting this cycle
- redirect_valid  input  1  flush and restart at redirect_pc
- redirect_pc  input  32  new fetch address
- instruction  output  32  head instruction; 32'h00000013 when queue empty
- program_counter  output  32  PC of head instruction; 0 when queue empty
- valid_out  output  1  head entry valid
- fetch_misaligned  output  1  see Optional Feature; tied 0 when compiled out

Behaviour:
- Reset (resetn low, asynchronous):
  - pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; state=S_START.
  - req_valid=0, valid_out=0, instruction=32'h00000013, program_counter=0, fetch_misaligned=0.
- States:
  - S_START: one cycle with no request, then unconditionally S_RUN.
  - S_RUN: normal fetching.
  - S_HALT: exists only with the macro; no requests.
- Issue rule:
  - req_valid = (state==S_RUN) && !redirect_valid && (outstanding + queue_count < FIFO_DEPTH).
  - req_addr = pc.
  - On req_valid&&req_ready: pc += 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000) and outstanding += 1.
- Response (resp_valid):
  - Always decrements outstanding.
  - If drop_cnt>0: response is discarded and drop_cnt -= 1.
  - Otherwise push {resp_data, pc_of_request} into the queue. Keep a separate tag-PC register, advanced by 4 per accepted push, to recover the PC.
  - The credit rule guarantees the queue never overflows. An overflow is a protocol error with undefined result.
- Output:
  - valid_out = queue non-empty; instruction/program_counter come from the queue head.
  - Pop when valid_out && !stall.
  - A push and a pop in the same cycle keep the count unchanged.
  - Fall-through is not required: minimum latency from request acceptance to valid_out is imem latency + 1 cycle.
- Redirect (redirect_valid high, takes precedence over everything):
  - Next cycle: queue empty (valid_out=0).
  - pc = tag-PC = redirect_pc with bits [1:0] cleared.
  - drop_cnt = outstanding count before this edge, minus 1 if a response arrives in the redirect cycle. That response is itself discarded.
  - No request is issued in the redirect cycle. Fetching resumes the following cycle.
- Simultaneous events:
  - Redirect beats pop and push.
  - Redirect while drop_cnt>0 adds the new outstanding count; stale responses are never enqueued.
  - Stall only freezes the head; requests continue until credits run out.
- Reset mid-operation clears all state. The environment guarantees the imem is also reset, so no stale responses arrive.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 moves to S_HALT and sets fetch_misaligned=1 (sticky).
  - In S_HALT no requests are issued, but stale responses are still drained.
  - An aligned redirect clears fetch_misaligned and returns to S_RUN.
- Undefined: low bits are silently cleared, fetch_misaligned is tied 0, and S_HALT is absent.

Test Plan:
- Reset release, imem latency 1, req_ready=1, stall=0:
  - no request in the first cycle; then req_addr 0x0, 0x4, 0x8 ...
  - valid_out rises with program_counter=0x0 and instruction=resp word, 2 cycles after the first acceptance.
- stall held high 10 cycles:
  - at most FIFO_DEPTH requests outstanding+queued;
  - head stays at 0x0 with its instruction unchanged;
  - after release, 0x0, 0x4 are presented in order with no gaps or duplicates.
- Redirect to 0x100 with 2 requests outstanding (latency 3):
  - both old responses are dropped; valid_out=0 until the response for 0x100;
  - next output PCs are 0x100, 0x104.
- Redirect in the same cycle as resp_valid and stall=0 with a valid head:
  - head not popped into the stream; response discarded;
  - first output after the redirect has program_counter=0x100.
- PC wrap: RESET_PC=0xFFFFFFF8 → outputs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → fetch_misaligned=1, req_valid stays 0; redirect to 0x200 → flag clears, fetch resumes at 0x200. Without the macro: redirect to 0x102 fetches 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited imem requests and an in-order response queue
// feeding IF/ID. Define FETCH_MISALIGN_TRAP_EN to trap (halt) on misaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] program_counter,
    output logic        valid_out,
    output logic        fetch_misaligned
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_HALT = 2'd2
`endif
    } state_t;

    state_t          state, state_next;
    logic [31:0]     pc, tag_pc;
    logic [CW-1:0]   outstanding, drop_cnt, count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [31:0]     pc_mem   [FIFO_DEPTH];
    logic [CW:0]     in_flight;
    logic            issue, dropping, push, pop;
    logic [31:0]     redirect_aligned;

    assign redirect_aligned = redirect_pc & ~32'h3;
    assign issue            = req_valid && req_ready;
    assign dropping         = resp_valid && (drop_cnt != '0);
    assign push             = resp_valid && !dropping;
    assign valid_out        = (count != '0);
    assign pop              = valid_out && !stall;
    assign req_addr         = pc;
    assign instruction      = valid_out ? data_mem[rd_ptr] : NOP;
    assign program_counter  = valid_out ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_START;
        else         state <= state_next;
    end

    // Queued entries count against the credit limit too, so the queue can never overflow.
    always_comb begin
        state_next = state;
        in_flight  = {1'b0, outstanding} + {1'b0, count};
        req_valid  = (state == S_RUN) && !redirect_valid && (in_flight < (CW+1)'(FIFO_DEPTH));
        case (state)
            S_START: state_next = S_RUN;
            default: state_next = state;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_valid)
            state_next = (redirect_pc[1:0] != 2'b00) ? S_HALT : S_RUN;
`endif
    end

    always_ff @(posedge clock) begin
        if (push && !redirect_valid) begin
            data_mem[wr_ptr] <= resp_data;
            pc_mem[wr_ptr]   <= tag_pc;
        end
    end

    // Every request still in flight at a redirect is stale; one arriving this cycle is dropped here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            tag_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_aligned;
            tag_pc      <= redirect_aligned;
            outstanding <= outstanding - CW'(resp_valid);
            drop_cnt    <= outstanding - CW'(resp_valid);
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (issue)    pc       <= pc + 32'd4;
            if (dropping) drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                tag_pc <= tag_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            outstanding <= outstanding + CW'(issue) - CW'(resp_valid);
            count       <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)             misaligned_q <= 1'b0;
        else if (redirect_valid) misaligned_q <= (redirect_pc[1:0] != 2'b00);
    end
    assign fetch_misaligned = misaligned_q;
`else
    assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem latency model, PC scoreboard, cycle table and corner sequences.
module tb_fetch_unit;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_ready, resp_valid, stall, redirect_valid;
    logic [31:0] resp_data, redirect_pc;
    bit          sel;

    logic        d_req_valid, d_valid_out, d_mis, w_req_valid, w_valid_out, w_mis;
    logic [31:0] d_req_addr, d_ins, d_pc, w_req_addr, w_ins, w_pc;
    logic        o_req_valid, o_valid_out, o_mis;
    logic [31:0] o_req_addr, o_ins, o_pc;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(d_req_valid), .req_addr(d_req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction(d_ins), .program_counter(d_pc), .valid_out(d_valid_out),
        .fetch_misaligned(d_mis));

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
        .clock(clock), .resetn(resetn),
        .req_valid(w_req_valid), .req_addr(w_req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction(w_ins), .program_counter(w_pc), .valid_out(w_valid_out),
        .fetch_misaligned(w_mis));

    assign o_req_valid = sel ? w_req_valid : d_req_valid;
    assign o_req_addr  = sel ? w_req_addr  : d_req_addr;
    assign o_valid_out = sel ? w_valid_out : d_valid_out;
    assign o_ins       = sel ? w_ins       : d_ins;
    assign o_pc        = sel ? w_pc        : d_pc;
    assign o_mis       = sel ? w_mis       : d_mis;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { bit stall; bit e_rv; logic [31:0] e_addr; bit e_vo; logic [31:0] e_pc; } vec_t;

    pend_t       pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] out_log[$];
    logic [31:0] exp_pc;
    int          cyc, lat, n_chk, n_pass, n_acc;
    logic        s_rv, s_vo, s_mis, s_resp;
    logic [31:0] s_addr, s_pc, s_ins;
    vec_t        tbl[8];

    function automatic logic [31:0] word_of(logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: drive the imem response, sample at settle time, score, advance.
    task automatic cycle();
        pend_t       p;
        logic [31:0] e;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            p = pending.pop_front();
            resp_valid = 1'b1;
            resp_data  = word_of(p.addr);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
        #1;
        s_rv = o_req_valid; s_addr = o_req_addr; s_vo = o_valid_out;
        s_pc = o_pc; s_ins = o_ins; s_mis = o_mis; s_resp = resp_valid;
        if (o_req_valid && req_ready) begin
            n_acc++;
            chk("req_addr", o_req_addr, exp_pc);
            pending.push_back('{o_req_addr, cyc + lat});
            exp_q.push_back(exp_pc);
            exp_pc += 32'd4;
            chk("credit_limit", 32'(exp_q.size() <= DEPTH), 32'd1);
        end
        if (redirect_valid) begin
            chk("redirect_no_req", 32'(o_req_valid), 32'd0);
            exp_q.delete();
            exp_pc = redirect_pc & ~32'h3;
        end else if (o_valid_out && !stall) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_out: got pc %h expected no output (cycle %0d)", o_pc, cyc);
            end else begin
                e = exp_q.pop_front();
                out_log.push_back(o_pc);
                chk("out_pc", o_pc, e);
                chk("out_instr", o_ins, word_of(e));
            end
        end
        if (!o_valid_out) begin
            chk("empty_instr", o_ins, NOP);
            chk("empty_pc", o_pc, 32'd0);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset(bit use_w);
        sel = use_w;
        resetn = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
        pending.delete(); exp_q.delete(); out_log.delete();
        n_acc = 0;
        exp_pc = use_w ? 32'hFFFF_FFF8 : 32'h0;
        @(negedge clock);
        #1;
        chk("rst_req_valid", 32'(o_req_valid), 32'd0);
        chk("rst_valid_out", 32'(o_valid_out), 32'd0);
        chk("rst_instr", o_ins, NOP);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_misaligned", 32'(o_mis), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        cyc = 0;
    endtask

    task automatic run_until_out(int n, int budget);
        for (int i = 0; i < budget && out_log.size() < n; i++) cycle();
        chk("output_timeout", 32'(out_log.size() >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; lat = 1; cyc = 0;
        tbl[0] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'h4,  1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h8,  1'b1, 32'h4};
        tbl[5] = '{1'b0, 1'b1, 32'hC,  1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8};
        tbl[7] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC};

        // Cycle-exact start-up, imem latency 1
        do_reset(1'b0);
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            stall = tbl[i].stall;
            cycle();
            chk("tbl_req_valid", 32'(s_rv), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk("tbl_req_addr", s_addr, tbl[i].e_addr);
            chk("tbl_valid_out", 32'(s_vo), 32'(tbl[i].e_vo));
            chk("tbl_pc", s_pc, tbl[i].e_pc);
        end

        // Stall held for 10 cycles from reset
        do_reset(1'b0);
        lat = 1;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_vo) begin
                chk("stall_head_pc", s_pc, 32'h0);
                chk("stall_head_instr", s_ins, word_of(32'h0));
            end
        end
        chk("stall_head_valid", 32'(s_vo), 32'd1);
        chk("stall_accepts", 32'(n_acc), 32'(DEPTH));
        stall = 1'b0;
        run_until_out(4, 20);
        chk("stall_rel_0", out_log[0], 32'h0);
        chk("stall_rel_1", out_log[1], 32'h4);

        // Redirect with two requests outstanding, imem latency 3
        do_reset(1'b0);
        lat = 3;
        repeat (3) cycle();
        chk("pending_before_redirect", 32'(pending.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        out_log.delete();
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("valid_after_redirect", 32'(s_vo), 32'd0);
        run_until_out(2, 30);
        chk("redir3_out0", out_log[0], 32'h100);
        chk("redir3_out1", out_log[1], 32'h104);

        // Redirect coinciding with a response and an unstalled valid head
        do_reset(1'b0);
        lat = 1;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b0;
        out_log.delete();
        cycle();
        chk("redir_head_valid", 32'(s_vo), 32'd1);
        chk("redir_resp_same_cycle", 32'(s_resp), 32'd1);
        redirect_valid = 1'b0;
        run_until_out(2, 30);
        chk("redir1_out0", out_log[0], 32'h100);

        // PC wrap from RESET_PC 0xFFFFFFF8
        do_reset(1'b1);
        lat = 1;
        run_until_out(3, 30);
        chk("wrap_out0", out_log[0], 32'hFFFF_FFF8);
        chk("wrap_out1", out_log[1], 32'hFFFF_FFFC);
        chk("wrap_out2", out_log[2], 32'h0000_0000);

        // Misaligned redirect
        do_reset(1'b0);
        lat = 2;
        repeat (5) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        out_log.delete();
        cycle();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("halt_no_req", 32'(s_rv), 32'd0);
            chk("halt_flag", 32'(s_mis), 32'd1);
            chk("halt_no_out", 32'(s_vo), 32'd0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("flag_cleared", 32'(s_mis), 32'd0);
        run_until_out(1, 30);
        chk("resume_pc", out_log[0], 32'h200);
`else
        run_until_out(1, 30);
        chk("misalign_cleared_pc", out_log[0], 32'h100);
        chk("misalign_flag_tied", 32'(s_mis), 32'd0);
`endif

        // Random stall / ready / redirect stress against the scoreboard
        do_reset(1'b0);
        lat = $urandom_range(1, 4);
        out_log.delete();
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom % 10) < 3;
            req_ready      = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 40) == 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc    = $urandom & ~32'h3;
`else
            redirect_pc    = $urandom;
`endif
            cycle();
        end
        stall = 1'b0; req_ready = 1'b1; redirect_valid = 1'b0;
        repeat (20) cycle();
        chk("stress_progress", 32'(out_log.size() > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
